// File: rtl/seg_scan.sv
// Eight-digit multiplexing scanner for a common-anode 7-segment display.
// Display contents change only on frame boundaries; each slot opens with a blanking window.
module seg_scan #(
    parameter int DIV   = 100000,
    parameter int BLANK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en_in,
    input  logic        load,
    output logic [3:0]  hex,
    output logic        dp,
    output logic [7:0]  AN,
    output logic        pend,
    output logic        frame_tick
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          pv_q, pv_d;
    logic [31:0]   p_data_q, p_data_d, s_data_q, s_data_d;
    logic [7:0]    p_dp_q, p_dp_d, p_en_q, p_en_d;
    logic [7:0]    s_dp_q, s_dp_d, s_en_q, s_en_d;
    logic [3:0]    hex_q, hex_d;
    logic          dp_q, dp_d;
    logic [7:0]    an_q, an_d;
    logic          ft_q, ft_d;
    logic          tick, wrap;

    assign tick = (cnt_q == CW'(DIV - 1));
    assign wrap = tick && (idx_q == 3'd7);

    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + CW'(1);
        idx_d    = tick ? idx_q + 3'd1 : idx_q;
        pv_d     = pv_q;
        p_data_d = p_data_q;
        p_dp_d   = p_dp_q;
        p_en_d   = p_en_q;
        s_data_d = s_data_q;
        s_dp_d   = s_dp_q;
        s_en_d   = s_en_q;
        // A load coinciding with the wrap bypasses the pending stage entirely
        if (wrap) begin
            pv_d = 1'b0;
            if (load) begin
                s_data_d = data;
                s_dp_d   = dp_in;
                s_en_d   = en_in;
            end else if (pv_q) begin
                s_data_d = p_data_q;
                s_dp_d   = p_dp_q;
                s_en_d   = p_en_q;
            end
        end else if (load) begin
            p_data_d = data;
            p_dp_d   = dp_in;
            p_en_d   = en_in;
            pv_d     = 1'b1;
        end

        // Outputs are derived from post-edge state so they line up with cnt/idx
        hex_d = s_data_d[{idx_d, 2'b00} +: 4];
        dp_d  = ~s_dp_d[idx_d];
        an_d  = ~(8'b1 << idx_d);
        if ((int'(cnt_d) < BLANK) || !s_en_d[idx_d]) begin
            an_d = 8'hFF;
        end
        ft_d = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            pv_q     <= 1'b0;
            p_data_q <= 32'h0;
            p_dp_q   <= 8'h00;
            p_en_q   <= 8'h00;
            s_data_q <= 32'h0;
            s_dp_q   <= 8'h00;
            s_en_q   <= 8'h00;
            hex_q    <= 4'h0;
            dp_q     <= 1'b1;
            an_q     <= 8'hFF;
            ft_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pv_q     <= pv_d;
            p_data_q <= p_data_d;
            p_dp_q   <= p_dp_d;
            p_en_q   <= p_en_d;
            s_data_q <= s_data_d;
            s_dp_q   <= s_dp_d;
            s_en_q   <= s_en_d;
            hex_q    <= hex_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
            ft_q     <= ft_d;
        end
    end

    assign hex        = hex_q;
    assign dp         = dp_q;
    assign AN         = an_q;
    assign pend       = pv_q;
    assign frame_tick = ft_q;
endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: scenario tasks compared against a cycle-count based display model.
module tb_seg_scan;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] data = 32'h0;
    logic [7:0]  dp_in = 8'h00;
    logic [7:0]  en_in = 8'h00;
    logic        load = 1'b0;
    logic [3:0]  hex;
    logic        dp;
    logic [7:0]  AN;
    logic        pend;
    logic        frame_tick;
    logic [14:0] dut_vec;

    int tests_run = 0;
    int failures  = 0;

    seg_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .dp_in(dp_in), .en_in(en_in),
        .load(load), .hex(hex), .dp(dp), .AN(AN), .pend(pend), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    assign dut_vec = {hex, dp, AN, pend, frame_tick};

    // Model: m_k counts clock edges since reset; slot and frame position follow arithmetically
    int          m_k;
    logic        m_pv;
    logic [31:0] m_pd, m_sd;
    logic [7:0]  m_pdp, m_pen, m_sdp, m_sen;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k <= 0; m_pv <= 1'b0;
            m_pd <= 32'h0; m_pdp <= 8'h00; m_pen <= 8'h00;
            m_sd <= 32'h0; m_sdp <= 8'h00; m_sen <= 8'h00;
        end else begin
            m_k <= m_k + 1;
            if (m_k % FRAME == FRAME - 1) begin
                m_pv <= 1'b0;
                if (load) begin
                    m_sd <= data; m_sdp <= dp_in; m_sen <= en_in;
                end else if (m_pv) begin
                    m_sd <= m_pd; m_sdp <= m_pdp; m_sen <= m_pen;
                end
            end else if (load) begin
                m_pd <= data; m_pdp <= dp_in; m_pen <= en_in; m_pv <= 1'b1;
            end
        end
    end

    function automatic logic [14:0] exp_vec();
        int c, ix;
        logic [7:0] an;
        c  = m_k % DIV;
        ix = (m_k / DIV) % 8;
        an = (c < BLANK || !m_sen[ix]) ? 8'hFF : ~(8'h01 << ix);
        return {m_sd[4*ix +: 4], ~m_sdp[ix], an, m_pv, (m_k != 0 && m_k % FRAME == 0)};
    endfunction

    task automatic goto_pos(input int pos);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_k % FRAME == pos) break;
            @(negedge clk);
        end
    endtask

    task automatic pulse_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
        data = d; dp_in = p; en_in = e; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load = 1'b1; data = $urandom; dp_in = 8'hFF; en_in = 8'hFF;
        repeat (3) @(negedge clk);
        tests_run++;
        if (dut_vec !== {4'h0, 1'b1, 8'hFF, 1'b0, 1'b0})
            $display("FAIL reset_vals: got %h expected %h", dut_vec, {4'h0, 1'b1, 8'hFF, 1'b0, 1'b0});
        load = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            tests_run++;
            if (AN !== 8'hFF || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL reset_dark k=%0d: got %h expected %h", m_k, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_basic();
        pulse_load(32'h12345678, 8'h01, 8'hFF);
        tests_run++;
        if (pend !== 1'b1) begin
            failures++;
            $display("FAIL basic_pend: got %b expected 1", pend);
        end
        for (int i = 0; i < FRAME + 2 && m_k % FRAME != 0; i++) begin
            @(negedge clk);
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL basic_wait k=%0d: got %h expected %h", m_k, dut_vec, exp_vec());
            end
        end
        for (int j = 0; j < FRAME; j++) begin
            if (j > 0) @(negedge clk);
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL basic_frame j=%0d: got %h expected %h", j, dut_vec, exp_vec());
            end
            if (j == 0) begin
                tests_run++;
                if ({frame_tick, hex, dp, AN} !== {1'b1, 4'h8, 1'b0, 8'hFF}) begin
                    failures++;
                    $display("FAIL basic_start: got %h expected %h", {frame_tick, hex, dp, AN}, {1'b1, 4'h8, 1'b0, 8'hFF});
                end
            end else if (j >= 2 && j <= 7) begin
                tests_run++;
                if (AN !== 8'hFE) begin
                    failures++;
                    $display("FAIL basic_slot0 j=%0d: got %h expected fe", j, AN);
                end
            end else if (j == 10) begin
                tests_run++;
                if ({hex, dp, AN} !== {4'h7, 1'b1, 8'hFD}) begin
                    failures++;
                    $display("FAIL basic_slot1: got %h expected %h", {hex, dp, AN}, {4'h7, 1'b1, 8'hFD});
                end
            end else if (j == 58) begin
                tests_run++;
                if ({hex, AN} !== {4'h1, 8'h7F}) begin
                    failures++;
                    $display("FAIL basic_slot7: got %h expected %h", {hex, AN}, {4'h1, 8'h7F});
                end
            end
        end
    endtask

    task automatic test_enable();
        goto_pos(FRAME - 1);
        pulse_load(32'h12345678, 8'h00, 8'h0F);
        for (int j = 0; j < FRAME; j++) begin
            if (j > 0) @(negedge clk);
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL enable_frame j=%0d: got %h expected %h", j, dut_vec, exp_vec());
            end
            if (j >= 4 * DIV) begin
                tests_run++;
                if (AN !== 8'hFF || hex !== 4'(8 - j / DIV)) begin
                    failures++;
                    $display("FAIL enable_dark j=%0d: got AN=%h hex=%h expected AN=ff hex=%h", j, AN, hex, 4'(8 - j / DIV));
                end
            end
        end
    endtask

    task automatic test_midframe();
        logic [31:0] shown;
        int ix;
        shown = 32'h12345678;
        goto_pos(FRAME - 1);
        pulse_load(shown, 8'h01, 8'hFF);
        goto_pos(3 * DIV + int'($urandom_range(0, DIV - 1)));
        pulse_load(32'hAAAAAAAA, 8'h00, 8'hFF);
        tests_run++;
        if (pend !== 1'b1) begin
            failures++;
            $display("FAIL mid_pend: got %b expected 1", pend);
        end
        for (int i = 0; i < FRAME && m_k % FRAME != 0; i++) begin
            ix = (m_k / DIV) % 8;
            tests_run++;
            if (hex !== shown[4*ix +: 4] || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL mid_hold k=%0d: got %h expected %h", m_k, dut_vec, exp_vec());
            end
            @(negedge clk);
        end
        for (int j = 0; j < FRAME; j++) begin
            if (j > 0) @(negedge clk);
            tests_run++;
            if (hex !== 4'hA || pend !== 1'b0 || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL mid_new j=%0d: got %h expected %h", j, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_wrap_collision();
        goto_pos(2 * DIV + int'($urandom_range(0, DIV - 1)));
        pulse_load(32'h0, 8'h00, 8'hFF);
        goto_pos(FRAME - 1);
        pulse_load(32'hFFFFFFFF, 8'h00, 8'hFF);
        for (int j = 0; j < FRAME; j++) begin
            if (j > 0) @(negedge clk);
            tests_run++;
            if (hex !== 4'hF || pend !== 1'b0 || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL wrap_coll j=%0d: got %h expected %h", j, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        goto_pos(5 * DIV + 4);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (dut_vec !== {4'h0, 1'b1, 8'hFF, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_rst: got %h expected %h", dut_vec, {4'h0, 1'b1, 8'hFF, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            tests_run++;
            if (AN !== 8'hFF || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL async_dark k=%0d: got %h expected %h", m_k, dut_vec, exp_vec());
            end
        end
        pulse_load($urandom, 8'($urandom), 8'hFF);
        for (int i = 0; i < FRAME && m_k % FRAME != 0; i++) begin
            tests_run++;
            if (AN !== 8'hFF) begin
                failures++;
                $display("FAIL async_wait k=%0d: got %h expected ff", m_k, AN);
            end
            @(negedge clk);
        end
        for (int j = 0; j < DIV; j++) begin
            if (j > 0) @(negedge clk);
            tests_run++;
            if (AN !== ((j < BLANK) ? 8'hFF : 8'hFE) || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL async_first j=%0d: got %h expected %h", j, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random k=%0d: got %h expected %h", m_k, dut_vec, exp_vec());
            end
            data = $urandom; dp_in = 8'($urandom); en_in = 8'($urandom);
            if (m_k % FRAME == FRAME - 1) load = ($urandom_range(0, 1) == 1);
            else load = ($urandom_range(0, 5) == 0);
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_enable();
        test_midframe();
        test_wrap_collision();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
